// File: rtl/button_pkg.sv
// -----------------------------------------------------------------------------
// button_pkg
// Shared constants for the push-button event front end:
//   - event codes reported on evt_code (0 = no event / FIFO empty)
//   - debounce FSM state encoding used by btn_debounce
//   - btn_code(): maps a button index (0=U,1=R,2=D,3=L) to its event code
// No ports (package).
// -----------------------------------------------------------------------------
package button_pkg;

  // Event codes as seen by software on the MMIO read port.
  localparam logic [2:0] BTN_NONE  = 3'd0;
  localparam logic [2:0] BTN_UP    = 3'd1;
  localparam logic [2:0] BTN_RIGHT = 3'd2;
  localparam logic [2:0] BTN_DOWN  = 3'd3;
  localparam logic [2:0] BTN_LEFT  = 3'd4;

  // Debounce FSM encoding.
  localparam logic [1:0] ST_RELEASED     = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] ST_PRESSED      = 2'd2;
  localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

  // Button index 0..3 (U,R,D,L) -> event code 1..4.
  function automatic logic [2:0] btn_code(input logic [1:0] idx);
    return {1'b0, idx} + 3'd1;
  endfunction

endpackage

// File: rtl/button_event_ctrl_if.sv
// -----------------------------------------------------------------------------
// button_event_ctrl_if
// Event read port between the button front end and the processor MMIO logic.
//   evt_valid    : FIFO non-empty, evt_code holds the head event
//   evt_code     : head event code (1=U 2=R 3=D 4=L), 0 when empty
//   evt_ready    : pop strobe from the consumer
//   fifo_count   : number of queued events
//   held         : debounced button levels {L,D,R,U}
//   overflow     : sticky "event dropped" flag
//   clr_overflow : clears overflow
// Modports: master = event producer (button_event_ctrl), slave = consumer.
// -----------------------------------------------------------------------------
interface button_event_ctrl_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic             evt_valid;
  logic [2:0]       evt_code;
  logic             evt_ready;
  logic [CNT_W-1:0] fifo_count;
  logic [3:0]       held;
  logic             overflow;
  logic             clr_overflow;

  modport master (
    output evt_valid, evt_code, fifo_count, held, overflow,
    input  evt_ready, clr_overflow
  );

  modport slave (
    input  evt_valid, evt_code, fifo_count, held, overflow,
    output evt_ready, clr_overflow
  );

endinterface

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// One push-button: 2-flop synchronizer, debounce FSM with stability counter,
// and a 1-cycle press pulse on every accepted press.
// Optional feature macro: BTN_AUTOREPEAT_EN -- while the button stays in
// PRESSED, further press pulses are produced after REPEAT_DELAY cycles and
// then every REPEAT_PERIOD cycles. Without the macro no repeat timer exists.
// Ports:
//   clk     in  system clock
//   reset   in  asynchronous active-high reset
//   btn_i   in  raw asynchronous button level
//   held_o  out debounced level (1 in PRESSED and RELEASE_WAIT)
//   press_o out 1-cycle pulse, registered, on entry to PRESSED (and repeats)
// -----------------------------------------------------------------------------
module btn_debounce
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 20000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic held_o,
  output logic press_o
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);

  generate
    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
      $error("btn_debounce: cycle parameters must be >= 1");
    end
  endgenerate

  logic            sync1_q, sync2_q;
  logic [1:0]      state_q, state_d;
  logic [DB_W-1:0] cnt_q, cnt_d;
  logic            press_q, press_d;
  logic            rep_fire;

  // Two-stage synchronizer; sync2_q is the only copy the FSM looks at.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  // A level change is accepted after DEBOUNCE_CYCLES+1 consecutive samples
  // of the new level: the first sample enters the WAIT state with count 1,
  // the transition fires on the sample that finds count == DEBOUNCE_CYCLES.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = rep_fire;
    case (state_q)
      ST_RELEASED: begin
        if (sync2_q) begin
          state_d = ST_PRESS_WAIT;
          cnt_d   = DB_ONE;
        end
      end
      ST_PRESS_WAIT: begin
        if (!sync2_q) begin
          state_d = ST_RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + DB_ONE;
        end
      end
      ST_PRESSED: begin
        if (!sync2_q) begin
          state_d = ST_RELEASE_WAIT;
          cnt_d   = DB_ONE;
        end
      end
      ST_RELEASE_WAIT: begin
        // A glitch back to 1 returns to PRESSED silently: still the same press.
        if (sync2_q) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = ST_RELEASED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + DB_ONE;
        end
      end
      default: begin
        state_d = ST_RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RELEASED;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RP_W   = $clog2(RP_MAX + 1);

  logic [RP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic            rep_first_q, rep_first_d;
  logic [RP_W-1:0] rep_limit;
  logic            stay_pressed;

  // Timer only runs while the button remains in PRESSED; any other state
  // (including a RELEASE_WAIT glitch) restarts the initial delay.
  assign stay_pressed = (state_q == ST_PRESSED) && sync2_q;
  assign rep_limit    = rep_first_q ? RP_W'(REPEAT_DELAY - 1) : RP_W'(REPEAT_PERIOD - 1);
  assign rep_fire     = stay_pressed && (rep_cnt_q == rep_limit);

  always_comb begin
    rep_cnt_d   = '0;
    rep_first_d = 1'b1;
    if (stay_pressed) begin
      if (rep_fire) begin
        rep_cnt_d   = '0;
        rep_first_d = 1'b0;
      end else begin
        rep_cnt_d   = rep_cnt_q + RP_W'(1);
        rep_first_d = rep_first_q;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b1;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_first_q <= rep_first_d;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  assign held_o  = (state_q == ST_PRESSED) || (state_q == ST_RELEASE_WAIT);
  assign press_o = press_q;

endmodule

// File: rtl/button_event_ctrl.sv
// -----------------------------------------------------------------------------
// button_event_ctrl
// Front end between four board push-buttons and the processor MMIO read port.
// Each button is synchronized and debounced (btn_debounce); accepted presses
// become pending bits, a fixed-priority arbiter (U>R>D>L) pushes one event
// per cycle into a small FIFO which software pops with evt_ready.
// Optional feature macro: BTN_AUTOREPEAT_EN (auto-repeat while held).
// Ports:
//   clk                  in  system clock
//   reset                in  asynchronous active-high reset
//   BTNU/BTNR/BTND/BTNL  in  raw asynchronous button levels
//   evt_if               master modport of button_event_ctrl_if
//                        (evt_valid, evt_code, evt_ready, fifo_count,
//                         held, overflow, clr_overflow)
// -----------------------------------------------------------------------------
module button_event_ctrl
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int FIFO_DEPTH      = 4,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 20000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 BTNU,
  input  logic                 BTNR,
  input  logic                 BTND,
  input  logic                 BTNL,
  button_event_ctrl_if.master  evt_if
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  generate
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("button_event_ctrl: FIFO_DEPTH must be a power of two >= 2");
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Per-button debounce
  // ---------------------------------------------------------------------------
  logic [3:0] btn_raw;
  logic [3:0] held_vec;
  logic [3:0] press_vec;

  assign btn_raw = {BTNL, BTND, BTNR, BTNU};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_btn
      btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD)
      ) u_btn_debounce (
        .clk     (clk),
        .reset   (reset),
        .btn_i   (btn_raw[gi]),
        .held_o  (held_vec[gi]),
        .press_o (press_vec[gi])
      );
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Pending bits + fixed-priority arbiter
  // ---------------------------------------------------------------------------
  // press_vec is already a registered pulse, so it is merged with the stored
  // pending bits here; an uncontended press is pushed on the very next edge.
  logic [3:0] pending_q, pending_d;
  logic [3:0] eff_pending;
  logic [1:0] grant_idx;
  logic       grant_vld;
  logic [2:0] push_code;

  assign eff_pending = pending_q | press_vec;

  // Descending scan: the last hit is the lowest index, i.e. highest priority.
  always_comb begin
    grant_idx = 2'd0;
    grant_vld = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (eff_pending[i]) begin
        grant_idx = 2'(i);
        grant_vld = 1'b1;
      end
    end
  end

  // The granted bit is cleared whether or not the FIFO accepts the push.
  always_comb begin
    pending_d = eff_pending;
    if (grant_vld) begin
      pending_d[grant_idx] = 1'b0;
    end
  end

  assign push_code = btn_code(grant_idx);

  // ---------------------------------------------------------------------------
  // Event FIFO
  // ---------------------------------------------------------------------------
  logic [2:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             fifo_empty, fifo_full;
  logic             pop, push_ok, drop;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_FULL);

  // A pop in the same cycle frees the slot, so full+pop+push is accepted.
  assign pop     = evt_if.evt_ready && !fifo_empty;
  assign push_ok = grant_vld && (!fifo_full || pop);
  assign drop    = grant_vld && fifo_full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q + (push_ok ? PTR_W'(1) : PTR_W'(0));
    rd_ptr_d = rd_ptr_q + (pop     ? PTR_W'(1) : PTR_W'(0));
    count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop);
    // A drop in the same cycle as the clear keeps the flag set.
    if (drop) begin
      overflow_d = 1'b1;
    end else if (evt_if.clr_overflow) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: entries are only visible through count_q.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_code;
    end
  end

  // All outputs come from registers only; evt_ready never reaches evt_valid
  // combinationally.
  assign evt_if.evt_valid  = !fifo_empty;
  assign evt_if.evt_code   = fifo_empty ? BTN_NONE : mem_q[rd_ptr_q];
  assign evt_if.fifo_count = count_q;
  assign evt_if.held       = held_vec;
  assign evt_if.overflow   = overflow_q;

endmodule

// File: tb/tb_button_event_ctrl.sv
// Self-checking bench for button_event_ctrl. A behavioural model tracks each
// button as "level flips after DEBOUNCE_CYCLES+1 consecutive opposite synced
// samples", keeps pending presses as flags and the FIFO as a queue.
module tb_button_event_ctrl;

  localparam int D  = 8;
  localparam int FD = 4;
  localparam int RD = 40;
  localparam int RP = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] btn = 4'b0;

  int n_assert = 0;
  int n_fail   = 0;

  button_event_ctrl_if #(.FIFO_DEPTH(FD)) evt_if ();

  button_event_ctrl #(
    .DEBOUNCE_CYCLES (D),
    .FIFO_DEPTH      (FD),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk    (clk),
    .reset  (rst),
    .BTNU   (btn[0]),
    .BTNR   (btn[1]),
    .BTND   (btn[2]),
    .BTNL   (btn[3]),
    .evt_if (evt_if)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit m_s1 [4];
  bit m_s2 [4];
  bit m_held [4];
  int m_run [4];
  int m_age [4];
  bit m_pend [4];
  bit m_ov;
  int q [$];

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_s1[i] = 0; m_s2[i] = 0; m_held[i] = 0;
      m_run[i] = 0; m_age[i] = -1; m_pend[i] = 0;
    end
    m_ov = 0;
    q.delete();
  endtask

  task automatic model_step();
    bit pop, accept, drop, s;
    int g;
    pop = evt_if.evt_ready && (q.size() > 0);
    accept = 0; drop = 0; g = -1;
    for (int i = 0; i < 4; i++) if (m_pend[i] && g < 0) g = i;
    if (g >= 0) begin
      m_pend[g] = 0;
      if (q.size() < FD || pop) accept = 1; else drop = 1;
    end
    if (pop) void'(q.pop_front());
    if (accept) q.push_back(g + 1);
    if (drop) m_ov = 1; else if (evt_if.clr_overflow) m_ov = 0;
    for (int i = 0; i < 4; i++) begin
      s = m_s2[i];
`ifdef BTN_AUTOREPEAT_EN
      if (m_held[i]) begin
        if (s) begin
          m_age[i]++;
          if (m_age[i] == RD || (m_age[i] > RD && (m_age[i] - RD) % RP == 0)) m_pend[i] = 1;
        end else begin
          m_age[i] = -1;
        end
      end
`endif
      if (s != m_held[i]) begin
        m_run[i]++;
        if (m_run[i] == D + 1) begin
          m_held[i] = s;
          m_run[i] = 0;
          if (s) begin
            m_pend[i] = 1;
            m_age[i] = 0;
          end
        end
      end else begin
        m_run[i] = 0;
      end
      m_s2[i] = m_s1[i];
      m_s1[i] = btn[i];
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [3:0] exp_held;
    for (int i = 0; i < 4; i++) exp_held[i] = m_held[i];
    chk("evt_valid", 32'(evt_if.evt_valid), 32'(q.size() > 0));
    chk("evt_code", 32'(evt_if.evt_code), (q.size() > 0) ? 32'(q[0]) : 32'd0);
    chk("fifo_count", 32'(evt_if.fifo_count), 32'(q.size()));
    chk("held", 32'(evt_if.held), 32'(exp_held));
    chk("overflow", 32'(evt_if.overflow), 32'(m_ov));
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic pop_one();
    evt_if.evt_ready = 1'b1;
    tick();
    evt_if.evt_ready = 1'b0;
  endtask

  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk({tag, "_valid"}, 32'(evt_if.evt_valid), 32'd0);
    chk({tag, "_code"}, 32'(evt_if.evt_code), 32'd0);
    chk({tag, "_count"}, 32'(evt_if.fifo_count), 32'd0);
    chk({tag, "_held"}, 32'(evt_if.held), 32'd0);
    chk({tag, "_ovf"}, 32'(evt_if.overflow), 32'd0);
  endtask

  initial begin
    int lat;
    int exp_codes [4];
    int ev_cyc [$];
    int exp_cyc [$];
    logic prev_valid;

    evt_if.evt_ready = 1'b0;
    evt_if.clr_overflow = 1'b0;
    model_reset();

    // Reset state
    @(negedge clk);
    async_reset("reset");
    run(3);
    rst = 1'b0;
    run(2);

    // 1. single press latency and pop
    btn[0] = 1'b1;
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (evt_if.evt_valid) begin lat = c; break; end
    end
    chk("t1_latency", 32'(lat), 32'(D + 4));
    chk("t1_code", 32'(evt_if.evt_code), 32'd1);
    pop_one();
    chk("t1_empty_valid", 32'(evt_if.evt_valid), 32'd0);
    chk("t1_empty_code", 32'(evt_if.evt_code), 32'd0);
    btn[0] = 1'b0;
    run(D + 6);

    // 2. bouncing press and bouncing release
    btn[2] = 1'b1; run(3); btn[2] = 1'b0; run(3);
    btn[2] = 1'b1; run(3); btn[2] = 1'b0; run(3);
    btn[2] = 1'b1; run(D + 10);
    chk("t2_count", 32'(evt_if.fifo_count), 32'd1);
    chk("t2_code", 32'(evt_if.evt_code), 32'd3);
    chk("t2_held_d", 32'(evt_if.held[2]), 32'd1);
    pop_one();
    btn[2] = 1'b0; run(3); btn[2] = 1'b1; run(3);
    btn[2] = 1'b0; run(D + 10);
    chk("t2_release_count", 32'(evt_if.fifo_count), 32'd0);
    chk("t2_release_held", 32'(evt_if.held[2]), 32'd0);

    // 3. simultaneous presses drain in priority order
    btn = 4'hF;
    run(D + 3);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("t3_count_step", 32'(evt_if.fifo_count), 32'(k));
    end
    for (int k = 1; k <= 4; k++) begin
      chk("t3_pop_code", 32'(evt_if.evt_code), 32'(k));
      pop_one();
    end
    btn = 4'h0;
    run(D + 6);

    // 4. overflow on a fifth event
    btn = 4'hF;
    run(D + 8);
    btn = 4'h0;
    run(D + 6);
    btn[0] = 1'b1;
    run(D + 4);
    chk("t4_overflow", 32'(evt_if.overflow), 32'd1);
    chk("t4_count", 32'(evt_if.fifo_count), 32'(FD));
    chk("t4_head", 32'(evt_if.evt_code), 32'd1);
    evt_if.clr_overflow = 1'b1; tick(); evt_if.clr_overflow = 1'b0;
    chk("t4_clr", 32'(evt_if.overflow), 32'd0);
    btn[0] = 1'b0;
    run(D + 6);

    // 5. full FIFO, push and pop in the same cycle
    btn[1] = 1'b1;
    run(D + 3);
    evt_if.evt_ready = 1'b1; tick(); evt_if.evt_ready = 1'b0;
    chk("t5_count", 32'(evt_if.fifo_count), 32'(FD));
    chk("t5_overflow", 32'(evt_if.overflow), 32'd0);
    btn[1] = 1'b0;
    exp_codes = '{2, 3, 4, 2};
    for (int k = 0; k < 4; k++) begin
      chk("t5_pop_code", 32'(evt_if.evt_code), 32'(exp_codes[k]));
      pop_one();
    end
    run(D + 6);
    chk("t5_drained", 32'(evt_if.fifo_count), 32'd0);

    // 6. reset with events queued and a press mid-debounce
    btn = 4'b0101;
    run(D + 6);
    chk("t6_queued", 32'(evt_if.fifo_count), 32'd2);
    btn[1] = 1'b1;
    run(4);
    async_reset("t6_reset");
    btn = 4'b0010;
    run(2);
    rst = 1'b0;
    lat = 0;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (evt_if.evt_valid) begin lat = c; break; end
    end
    chk("t6_event_seen", 32'(lat > 0), 32'd1);
    chk("t6_code", 32'(evt_if.evt_code), 32'd2);
    run(5);
    chk("t6_single", 32'(evt_if.fifo_count), 32'd1);
    btn = 4'b0;
    pop_one();
    run(D + 6);

    // 7. long hold (auto-repeat when enabled)
    evt_if.evt_ready = 1'b1;
    run(4);
    prev_valid = evt_if.evt_valid;
    btn[3] = 1'b1;
    for (int c = 1; c <= 120; c++) begin
      tick();
      if (evt_if.evt_valid && !prev_valid) ev_cyc.push_back(c);
      prev_valid = evt_if.evt_valid;
      if (c == 100) btn[3] = 1'b0;
    end
    evt_if.evt_ready = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
    exp_cyc = '{12, 52, 68, 84, 100};
`else
    exp_cyc = '{12};
`endif
    chk("t7_event_count", 32'(ev_cyc.size()), 32'(exp_cyc.size()));
    for (int i = 0; i < exp_cyc.size(); i++) begin
      chk("t7_event_cycle", (i < ev_cyc.size()) ? 32'(ev_cyc[i]) : 32'hFFFF_FFFF, 32'(exp_cyc[i]));
    end
    run(D + 6);

    // Randomized phase against the model
    for (int c = 0; c < 2500; c++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 9) == 0) btn[b] = ~btn[b];
      end
      evt_if.evt_ready    = ($urandom_range(0, 3) == 0);
      evt_if.clr_overflow = ($urandom_range(0, 31) == 0);
      if (c == 1200) begin
        async_reset("rand_reset");
        run(2);
        rst = 1'b0;
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
